fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit for the 9-bit basic processor. Holds the program counter (PC), steps it every cycle, and redirects it when the control decoder asserts its jump or branch outputs. Branch and jump destinations come from an internal target lookup table (LUT) indexed by a field of the current instruction. The block runs a start/done handshake with the testbench/top level and keeps a cycle counter for performance reporting. It sits between the top level and the instruction ROM: its PC output drives the ROM address, and its redirect inputs come from the control decoder.

## Interface
- PC_W, 10, PC / instruction ROM address width
- LUT_DEPTH, 16, number of target LUT entries (index width = log2(LUT_DEPTH))
- START_ADDR, 0, PC value loaded on every program start
- CNT_W, 16, cycle counter width
- Clk  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  level; a rising edge (0→1 across two sampled cycles) begins a program run
- Halt  input  1  from control decoder; current instruction is a halt
- jump_en  input  1  from control decoder; unconditional redirect
- branch_en  input  1  from control decoder; taken branch (already qualified by ZERO)
- TargetIdx  input  log2(LUT_DEPTH)  LUT index taken from the current instruction
- LutWe  input  1  LUT write enable (honoured only in IDLE or DONE)
- LutAddr  input  log2(LUT_DEPTH)  LUT write index
- LutData  input  PC_W  LUT write data
- PC  output  PC_W  current instruction address
- Running  output  1  high while in RUN
- Done  output  1  high while in DONE
- CycleCount  output  CNT_W  number of RUN cycles in the current/last run

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: PC = START_ADDR, Running = 0, Done = 0, CycleCount holds. A Start rising edge moves to RUN and clears CycleCount to 0. PC stays START_ADDR on entry.
- RUN: every cycle, the next PC is chosen by strict priority:
  1. Halt → go to DONE, PC holds.
  2. jump_en → PC = LUT[TargetIdx].
  3. branch_en → PC = LUT[TargetIdx].
  4. Otherwise PC = PC + 1, modulo 2^PC_W (the maximum address wraps to 0).
- Halt in RUN wins over a simultaneous jump_en or branch_en; the redirect is discarded.
- DONE: PC, CycleCount and Done = 1 hold. A Start rising edge re-enters RUN with PC = START_ADDR and CycleCount = 0.
- Start edge detect: one internal register holding the previous Start. A Start level held high does not retrigger.
- Start edges in RUN are ignored.
- LUT: LUT_DEPTH × PC_W registers, all cleared to 0 on Reset.
  - Write when LutWe = 1 in IDLE or DONE; in RUN, writes are ignored.
  - Read is combinational in TargetIdx.
  - A write and a read of the same index in the same cycle is a don't-care; LUT writes are not allowed in RUN, so this never applies.
- CycleCount increments by 1 in every RUN cycle, including the cycle in which Halt is sampled. It saturates at 2^CNT_W − 1 (no wrap).
- Reset during any state returns to IDLE on the next edge:
  - PC = START_ADDR, CycleCount = 0, LUT cleared, Start history = 0.
  - Reset overrides Start, LutWe and Halt in the same cycle.

## Timing
- Reset values: PC = START_ADDR, Running = 0, Done = 0, CycleCount = 0, state = IDLE.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths.
- Start latency:
  - Start rises, sampled at edge N → state = RUN after N, Running = 1.
  - PC = START_ADDR is presented during cycle N+1; the first increment lands at edge N+1.
- Redirect latency: jump_en, branch_en and TargetIdx sampled at edge N → PC = target after edge N. The instruction at the target is fetched in cycle N+1, with no bubble.
- Halt sampled at edge N → Done = 1 and Running = 0 after N. PC keeps the halt instruction's address.
- LUT write at edge N is visible to reads from cycle N+1.

## Test plan
- Reset, then a Start pulse, no redirects: PC goes 0, 1, 2, 3, 4; Halt at PC = 4 → Done = 1, PC stays 4, CycleCount = 5.
- Write LUT[3] = 0x120 in IDLE, Start, then assert jump_en with TargetIdx = 3 at PC = 2: the next PC is 0x120 and the following PC is 0x121.
- Halt, jump_en and branch_en all asserted in the same cycle at PC = 7: Done = 1, PC stays 7, no redirect.
- With PC_W = 10, walk PC to 0x3FF: the next PC is 0x000. With CNT_W = 4, run 20 cycles: CycleCount saturates at 15.
- Start held high through DONE: no restart. Deassert, then reassert: RUN resumes with PC = 0 and CycleCount = 0. A LutWe in RUN (LUT[3] = 0x055) leaves LUT[3] unchanged.
- Reset asserted mid-RUN at PC = 0x40: on the next edge PC = 0, state = IDLE, Running = 0, and LUT[3] reads 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Purpose : groups the fetch unit's run-control, redirect, LUT-write and status signals.
// Ports   : master = top level / decoder side (drives Start, Halt, redirects, LUT writes);
//           slave  = fetch unit side (drives PC, Running, Done, CycleCount).
interface fetch_unit_if #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
);
    logic              Start;
    logic              Halt;
    logic              jump_en;
    logic              branch_en;
    logic [IDX_W-1:0]  TargetIdx;
    logic              LutWe;
    logic [IDX_W-1:0]  LutAddr;
    logic [PC_W-1:0]   LutData;
    logic [PC_W-1:0]   PC;
    logic              Running;
    logic              Done;
    logic [CNT_W-1:0]  CycleCount;

    modport master (
        output Start, Halt, jump_en, branch_en, TargetIdx, LutWe, LutAddr, LutData,
        input  PC, Running, Done, CycleCount
    );

    modport slave (
        input  Start, Halt, jump_en, branch_en, TargetIdx, LutWe, LutAddr, LutData,
        output PC, Running, Done, CycleCount
    );
endinterface

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch unit - PC stepping, LUT-based jump/branch redirect,
//           start/done run control and a saturating RUN-cycle counter.
// Ports   : Clk, Reset (synchronous, active high); bus (fetch_unit_if.slave) carries
//           Start/Halt/redirect/LUT-write inputs and PC/Running/Done/CycleCount outputs.
//           All outputs are registered or decoded from state.
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int LUT_DEPTH  = 16,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               start_q;
    logic [PC_W-1:0]    lut [LUT_DEPTH];

    logic               start_rise;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               lut_we;
    logic [PC_W-1:0]    target;

    assign start_rise = bus.Start & ~start_q;
    assign target     = lut[bus.TargetIdx];

    // A fresh run starts only from IDLE or DONE; edges seen while running are ignored.
    assign cnt_clr = (state != RUN) && start_rise;
    assign cnt_inc = (state == RUN) && (cnt != {CNT_W{1'b1}});
    assign lut_we  = bus.LutWe && (state != RUN);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: begin
                pc_nxt = PC_W'(START_ADDR);
                if (start_rise) state_nxt = RUN;
            end
            RUN: begin
                // Halt wins over any redirect; the halting instruction's address is kept.
                if (bus.Halt)                           state_nxt = DONE;
                else if (bus.jump_en || bus.branch_en)  pc_nxt    = target;
                else                                    pc_nxt    = pc + PC_W'(1);
            end
            DONE: begin
                if (start_rise) begin
                    state_nxt = RUN;
                    pc_nxt    = PC_W'(START_ADDR);
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = PC_W'(START_ADDR);
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            pc      <= PC_W'(START_ADDR);
            cnt     <= '0;
            start_q <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            start_q <= bus.Start;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);
            if (lut_we) lut[bus.LutAddr] <= bus.LutData;
        end
    end

    assign bus.PC         = pc;
    assign bus.Running    = (state == RUN);
    assign bus.Done       = (state == DONE);
    assign bus.CycleCount = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// compared against a plain behavioural model. A second instance with a 4-bit
// counter shares the stimulus to exercise counter saturation.
module tb_fetch_unit;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    fetch_unit_if #(.PC_W(10), .IDX_W(4), .CNT_W(16)) bus ();
    fetch_unit_if #(.PC_W(10), .IDX_W(4), .CNT_W(4))  bus_s ();

    assign bus_s.Start     = bus.Start;
    assign bus_s.Halt      = bus.Halt;
    assign bus_s.jump_en   = bus.jump_en;
    assign bus_s.branch_en = bus.branch_en;
    assign bus_s.TargetIdx = bus.TargetIdx;
    assign bus_s.LutWe     = bus.LutWe;
    assign bus_s.LutAddr   = bus.LutAddr;
    assign bus_s.LutData   = bus.LutData;

    fetch_unit #(.PC_W(10), .LUT_DEPTH(16), .START_ADDR(0), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus.slave));
    fetch_unit #(.PC_W(10), .LUT_DEPTH(16), .START_ADDR(0), .CNT_W(4)) dut_s (
        .Clk(Clk), .Reset(Reset), .bus(bus_s.slave));

    int chk = 0;
    int err = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = done.
    int m_st, m_pc, m_c16, m_c4;
    int m_lut [16];
    bit m_prev;

    wire [31:0] obs = {bus.Running, bus.Done, bus.PC, bus.CycleCount, bus_s.CycleCount};

    function automatic logic [31:0] model_vec();
        return {m_st == 1, m_st == 2, 10'(m_pc), 16'(m_c16), 4'(m_c4)};
    endfunction

    task automatic tick();
        bit rise;
        @(posedge Clk);
        if (Reset) begin
            m_st = 0; m_pc = 0; m_c16 = 0; m_c4 = 0; m_prev = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else begin
            rise   = bus.Start && !m_prev;
            m_prev = bus.Start;
            if (m_st == 1) begin
                m_c16 = (m_c16 < 65535) ? m_c16 + 1 : 65535;
                m_c4  = (m_c4 < 15) ? m_c4 + 1 : 15;
                if (bus.Halt)                          m_st = 2;
                else if (bus.jump_en || bus.branch_en) m_pc = m_lut[bus.TargetIdx];
                else                                   m_pc = (m_pc + 1) % 1024;
            end else begin
                if (bus.LutWe) m_lut[bus.LutAddr] = int'(bus.LutData);
                if (rise) begin
                    m_st = 1; m_pc = 0; m_c16 = 0; m_c4 = 0;
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.Start = 0; bus.Halt = 0; bus.jump_en = 0; bus.branch_en = 0;
        bus.TargetIdx = '0; bus.LutWe = 0; bus.LutAddr = '0; bus.LutData = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1;
        tick(); tick();
        chk++;
        if (obs !== 32'h0) begin
            err++; $display("FAIL reset_state got=%h want=%h", obs, 32'h0);
        end
        Reset = 0;
        tick();
        chk++;
        if (obs !== model_vec()) begin
            err++; $display("FAIL idle_hold got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_linear();
        bus.Start = 1; tick(); bus.Start = 0;
        for (int i = 0; i < 5; i++) begin
            chk++;
            if (bus.PC !== 10'(i) || bus.Running !== 1'b1) begin
                err++; $display("FAIL linear_pc got=%h run=%b want=%h", bus.PC, bus.Running, i);
            end
            if (i < 4) tick();
        end
        bus.Halt = 1; tick(); bus.Halt = 0;
        chk++;
        if (bus.Done !== 1'b1 || bus.Running !== 1'b0 || bus.PC !== 10'd4 || bus.CycleCount !== 16'd5) begin
            err++; $display("FAIL linear_halt got done=%b run=%b pc=%h cnt=%0d want done=1 run=0 pc=004 cnt=5",
                            bus.Done, bus.Running, bus.PC, bus.CycleCount);
        end
        tick();
        chk++;
        if (obs !== model_vec()) begin
            err++; $display("FAIL done_hold got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_jump();
        bus.LutWe = 1; bus.LutAddr = 4'd3; bus.LutData = 10'h120; tick();
        bus.LutAddr = 4'd5; bus.LutData = 10'h2A0; tick();
        bus.LutWe = 0;
        bus.Start = 1; tick(); bus.Start = 0;
        tick(); tick();
        chk++;
        if (bus.PC !== 10'd2) begin
            err++; $display("FAIL jump_pre got=%h want=002", bus.PC);
        end
        bus.jump_en = 1; bus.TargetIdx = 4'd3; tick(); bus.jump_en = 0;
        chk++;
        if (bus.PC !== 10'h120) begin
            err++; $display("FAIL jump_target got=%h want=120", bus.PC);
        end
        tick();
        chk++;
        if (bus.PC !== 10'h121) begin
            err++; $display("FAIL jump_next got=%h want=121", bus.PC);
        end
        bus.branch_en = 1; bus.TargetIdx = 4'd5; tick(); bus.branch_en = 0;
        chk++;
        if (bus.PC !== 10'h2A0) begin
            err++; $display("FAIL branch_target got=%h want=2a0", bus.PC);
        end
        bus.Halt = 1; tick(); bus.Halt = 0;
        chk++;
        if (obs !== model_vec()) begin
            err++; $display("FAIL jump_halt got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_halt_priority();
        bus.Start = 1; tick(); bus.Start = 0;
        repeat (7) tick();
        bus.Halt = 1; bus.jump_en = 1; bus.branch_en = 1; bus.TargetIdx = 4'd5;
        tick();
        bus.Halt = 0; bus.jump_en = 0; bus.branch_en = 0;
        chk++;
        if (bus.Done !== 1'b1 || bus.PC !== 10'd7 || bus.CycleCount !== 16'd8) begin
            err++; $display("FAIL halt_priority got done=%b pc=%h cnt=%0d want done=1 pc=007 cnt=8",
                            bus.Done, bus.PC, bus.CycleCount);
        end
    endtask

    task automatic test_wrap_saturate();
        bus.LutWe = 1; bus.LutAddr = 4'd1; bus.LutData = 10'h3FD; tick(); bus.LutWe = 0;
        bus.Start = 1; tick(); bus.Start = 0;
        bus.jump_en = 1; bus.TargetIdx = 4'd1; tick(); bus.jump_en = 0;
        tick(); tick();
        chk++;
        if (bus.PC !== 10'h3FF) begin
            err++; $display("FAIL wrap_top got=%h want=3ff", bus.PC);
        end
        tick();
        chk++;
        if (bus.PC !== 10'h000) begin
            err++; $display("FAIL wrap_zero got=%h want=000", bus.PC);
        end
        repeat (16) tick();
        chk++;
        if (bus.CycleCount !== 16'd20 || bus_s.CycleCount !== 4'd15) begin
            err++; $display("FAIL saturate got cnt16=%0d cnt4=%0d want 20 and 15",
                            bus.CycleCount, bus_s.CycleCount);
        end
        bus.Halt = 1; tick(); bus.Halt = 0;
        chk++;
        if (obs !== model_vec()) begin
            err++; $display("FAIL wrap_halt got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_start_held();
        bus.Start = 1; tick();
        tick(); tick();
        bus.Halt = 1; tick(); bus.Halt = 0;
        repeat (3) tick();
        chk++;
        if (bus.Done !== 1'b1 || bus.PC !== 10'd2) begin
            err++; $display("FAIL start_held got done=%b pc=%h want done=1 pc=002", bus.Done, bus.PC);
        end
        bus.Start = 0; tick();
        bus.Start = 1; tick(); bus.Start = 0;
        chk++;
        if (bus.Running !== 1'b1 || bus.PC !== 10'd0 || bus.CycleCount !== 16'd0) begin
            err++; $display("FAIL restart got run=%b pc=%h cnt=%0d want run=1 pc=000 cnt=0",
                            bus.Running, bus.PC, bus.CycleCount);
        end
        bus.LutWe = 1; bus.LutAddr = 4'd3; bus.LutData = 10'h055; tick(); bus.LutWe = 0;
        bus.jump_en = 1; bus.TargetIdx = 4'd3; tick(); bus.jump_en = 0;
        chk++;
        if (bus.PC !== 10'h120) begin
            err++; $display("FAIL run_lut_write got=%h want=120", bus.PC);
        end
    endtask

    task automatic test_reset_mid_run();
        bus.Halt = 1; tick(); bus.Halt = 0;
        bus.Start = 1; tick(); bus.Start = 0;
        repeat (64) tick();
        chk++;
        if (bus.PC !== 10'h040 || bus.Running !== 1'b1) begin
            err++; $display("FAIL mid_run_pc got=%h want=040", bus.PC);
        end
        Reset = 1; bus.Start = 1; bus.Halt = 1; tick(); Reset = 0;
        bus.Start = 0; bus.Halt = 0;
        chk++;
        if (bus.PC !== 10'd0 || bus.Running !== 1'b0 || bus.Done !== 1'b0 || bus.CycleCount !== 16'd0) begin
            err++; $display("FAIL reset_mid got pc=%h run=%b done=%b cnt=%0d want all zero",
                            bus.PC, bus.Running, bus.Done, bus.CycleCount);
        end
        bus.Start = 1; tick(); bus.Start = 0;
        bus.jump_en = 1; bus.TargetIdx = 4'd3; tick(); bus.jump_en = 0;
        chk++;
        if (bus.PC !== 10'd0) begin
            err++; $display("FAIL lut_cleared got=%h want=000", bus.PC);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            Reset         = ($urandom_range(299) == 0);
            bus.Start     = ($urandom_range(7) == 0) ? ~bus.Start : bus.Start;
            bus.Halt      = ($urandom_range(24) == 0);
            bus.jump_en   = ($urandom_range(9) == 0);
            bus.branch_en = ($urandom_range(9) == 0);
            bus.TargetIdx = 4'($urandom);
            bus.LutWe     = ($urandom_range(3) == 0);
            bus.LutAddr   = 4'($urandom);
            bus.LutData   = 10'($urandom);
            tick();
            chk++;
            if (obs !== model_vec()) begin
                err++;
                if (bad < 10) $display("FAIL random_cycle %0d got=%h want=%h", i, obs, model_vec());
                bad++;
            end
        end
        Reset = 0;
        clear_inputs();
    endtask

    initial begin
        m_st = 0; m_pc = 0; m_c16 = 0; m_c4 = 0; m_prev = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
        Reset = 1;
        clear_inputs();
        test_reset();
        test_linear();
        test_jump();
        test_halt_priority();
        test_wrap_saturate();
        test_start_held();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
